// File: rtl/readout_pulse_gen_pkg.sv
// Shared constants, state encoding and phase helpers for the readout tone generator.
package readout_pulse_gen_pkg;

    localparam int LANES       = 5;
    localparam int DATA_W      = 16;
    localparam int PHASE_STEPS = 50;
    localparam int LEN_W       = 11;
    localparam int FREQ_W      = 4;
    localparam int AMP_W       = 15;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic [5:0] phase_t;

    // Reduce a sum of at most 124 into 0..49 with two conditional subtracts.
    function automatic phase_t phase_wrap(input logic [6:0] sum);
        logic [6:0] r;
        r = sum;
        if (r >= 7'(PHASE_STEPS)) r = r - 7'(PHASE_STEPS);
        if (r >= 7'(PHASE_STEPS)) r = r - 7'(PHASE_STEPS);
        return phase_t'(r);
    endfunction

endpackage

// File: rtl/readout_pulse_gen_lut.sv
// Registered 50-point cos/sin ROM. The table holds one quarter wave
// (indices 0..12) and the remaining points are folded onto it with sign flips.
module readout_tone_lut
    import readout_pulse_gen_pkg::*;
(
    input  logic                     clk100,
    input  logic                     reset_n,
    input  phase_t                   phase,
    output logic signed [DATA_W-1:0] cos_val,
    output logic signed [DATA_W-1:0] sin_val
);

    logic [3:0] fold;
    logic       neg_c;
    logic       neg_s;

    function automatic logic signed [DATA_W-1:0] cos_q(input logic [3:0] i);
        case (i)
            4'd0:    cos_q = 16'sd32767;
            4'd1:    cos_q = 16'sd32509;
            4'd2:    cos_q = 16'sd31738;
            4'd3:    cos_q = 16'sd30466;
            4'd4:    cos_q = 16'sd28714;
            4'd5:    cos_q = 16'sd26509;
            4'd6:    cos_q = 16'sd23886;
            4'd7:    cos_q = 16'sd20886;
            4'd8:    cos_q = 16'sd17557;
            4'd9:    cos_q = 16'sd13952;
            4'd10:   cos_q = 16'sd10126;
            4'd11:   cos_q = 16'sd6140;
            4'd12:   cos_q = 16'sd2057;
            default: cos_q = 16'sd0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sin_q(input logic [3:0] i);
        case (i)
            4'd0:    sin_q = 16'sd0;
            4'd1:    sin_q = 16'sd4107;
            4'd2:    sin_q = 16'sd8149;
            4'd3:    sin_q = 16'sd12062;
            4'd4:    sin_q = 16'sd15786;
            4'd5:    sin_q = 16'sd19260;
            4'd6:    sin_q = 16'sd22431;
            4'd7:    sin_q = 16'sd25247;
            4'd8:    sin_q = 16'sd27666;
            4'd9:    sin_q = 16'sd29648;
            4'd10:   sin_q = 16'sd31163;
            4'd11:   sin_q = 16'sd32187;
            4'd12:   sin_q = 16'sd32702;
            default: sin_q = 16'sd0;
        endcase
    endfunction

    // Fold the full-circle index onto the quarter-wave table.
    always_comb begin
        fold  = '0;
        neg_c = 1'b0;
        neg_s = 1'b0;
        if (phase <= 6'd12) begin
            fold = phase[3:0];
        end else if (phase <= 6'd25) begin
            fold  = 4'(6'd25 - phase);
            neg_c = 1'b1;
        end else if (phase <= 6'd37) begin
            fold  = 4'(phase - 6'd25);
            neg_c = 1'b1;
            neg_s = 1'b1;
        end else begin
            fold  = 4'(6'd50 - phase);
            neg_s = 1'b1;
        end
    end

    // Register the signed cos/sin pair.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            cos_val <= '0;
            sin_val <= '0;
        end else begin
            cos_val <= neg_c ? -cos_q(fold) : cos_q(fold);
            sin_val <= neg_s ? -sin_q(fold) : sin_q(fold);
        end
    end

endmodule

// File: rtl/readout_pulse_gen.sv
// Readout tone generator: LANES parallel I/Q samples per clk100 beat on the
// 50-step phase grid shared with the receive demodulator.
//
// state | meaning
// IDLE  | waiting for start; config latched on acceptance
// RUN   | one beat issued per cycle until length reached or abort
// DRAIN | last issued beat moves from LUT register to output register
// DONE  | done strobe registered on the following edge, then back to IDLE
module readout_pulse_gen
    import readout_pulse_gen_pkg::*;
(
    input  logic                      clk100,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [FREQ_W-1:0]         demod_freq,
    input  logic [LEN_W-1:0]          pulse_length,
    input  logic [AMP_W-1:0]          amplitude,
    input  logic [5:0]                phase_offset,
    output logic                      busy,
    output logic                      done,
    output logic                      out_valid,
    output logic [LANES*DATA_W-1:0]   out_i,
    output logic [LANES*DATA_W-1:0]   out_q,
    output logic [LEN_W-1:0]          sample_count
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                issue;
    logic                last_beat;
    logic [FREQ_W-1:0]   cfg_freq;
    logic [AMP_W-1:0]    cfg_amp;
    logic [LEN_W-1:0]    beats_left;
    phase_t              base;
    phase_t              next_base;
    phase_t              acc;
    phase_t              offset_red;
    phase_t              lane_phase [LANES];
    logic                lut_valid;
    logic signed [DATA_W-1:0] lut_cos [LANES];
    logic signed [DATA_W-1:0] lut_sin [LANES];
    logic signed [DATA_W-1:0] amp_s;
    logic signed [31:0]  prod_i;
    logic signed [31:0]  prod_q;
    logic [LANES*DATA_W-1:0] out_i_nxt;
    logic [LANES*DATA_W-1:0] out_q_nxt;

    assign last_beat  = (beats_left == 11'd1);
    assign offset_red = (phase_offset >= 6'(PHASE_STEPS)) ? phase_offset - 6'(PHASE_STEPS)
                                                         : phase_offset;
    assign amp_s      = $signed({1'b0, cfg_amp});

    // State register.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and beat-issue decode. The final beat is issued even if abort
    // arrives with it, so such a pulse completes normally.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !busy) begin
                    accept    = 1'b1;
                    state_nxt = (pulse_length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!abort || last_beat) issue = 1'b1;
                if (abort || last_beat)  state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane phases step by f from base; the value after the last lane is base + 5f.
    always_comb begin
        lane_phase = '{default: '0};
        acc        = base;
        for (int k = 0; k < LANES; k++) begin
            lane_phase[k] = acc;
            acc = phase_wrap({1'b0, acc} + {3'b0, cfg_freq});
        end
        next_base = acc;
    end

    // Config latch, phase accumulator and beat down-counter.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            cfg_freq   <= '0;
            cfg_amp    <= '0;
            base       <= '0;
            beats_left <= '0;
        end else if (accept) begin
            cfg_freq   <= demod_freq;
            cfg_amp    <= amplitude;
            base       <= offset_red;
            beats_left <= pulse_length;
        end else if (issue) begin
            base       <= next_base;
            beats_left <= beats_left - 11'd1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lut
        readout_tone_lut u_lut (
            .clk100  (clk100),
            .reset_n (reset_n),
            .phase   (lane_phase[g]),
            .cos_val (lut_cos[g]),
            .sin_val (lut_sin[g])
        );
    end

    // Scale each LUT pair by the amplitude; arithmetic shift floors toward -inf.
    always_comb begin
        out_i_nxt = '0;
        out_q_nxt = '0;
        prod_i    = '0;
        prod_q    = '0;
        for (int k = 0; k < LANES; k++) begin
            prod_i = 32'(lut_cos[k]) * 32'(amp_s);
            prod_q = 32'(lut_sin[k]) * 32'(amp_s);
            out_i_nxt[k*DATA_W +: DATA_W] = DATA_W'(prod_i >>> 15);
            out_q_nxt[k*DATA_W +: DATA_W] = DATA_W'(prod_q >>> 15);
        end
    end

    // Pipeline valids, output register, status flags and beat count.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            lut_valid    <= 1'b0;
            out_valid    <= 1'b0;
            out_i        <= '0;
            out_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_count <= '0;
        end else begin
            lut_valid <= issue;
            out_valid <= lut_valid;
            out_i     <= lut_valid ? out_i_nxt : '0;
            out_q     <= lut_valid ? out_q_nxt : '0;
            busy      <= (state != IDLE);
            done      <= (state == DONE);
            if (accept)         sample_count <= '0;
            else if (lut_valid) sample_count <= sample_count + 11'd1;
        end
    end

endmodule

// File: tb/tb_readout_pulse_gen.sv
// Scoreboard bench for readout_pulse_gen: expected beats come from a
// floating-point cos/sin model and are popped as out_valid beats appear.
module tb_readout_pulse_gen;

    localparam real PI = 3.14159265358979323846;

    logic        clk100 = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [3:0]  demod_freq;
    logic [10:0] pulse_length;
    logic [14:0] amplitude;
    logic [5:0]  phase_offset;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [79:0] out_i;
    logic [79:0] out_q;
    logic [10:0] sample_count;

    typedef struct {
        logic [79:0] i;
        logic [79:0] q;
    } beat_t;

    beat_t sb[$];
    int    errs   = 0;
    int    checks = 0;

    always #5 clk100 = ~clk100;

    readout_pulse_gen dut (
        .clk100       (clk100),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .demod_freq   (demod_freq),
        .pulse_length (pulse_length),
        .amplitude    (amplitude),
        .phase_offset (phase_offset),
        .busy         (busy),
        .done         (done),
        .out_valid    (out_valid),
        .out_i        (out_i),
        .out_q        (out_q),
        .sample_count (sample_count)
    );

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic logic [15:0] scale(input int lut, input int amp);
        int pr;
        pr = lut * amp;
        return 16'(pr >>> 15);
    endfunction

    function automatic logic [15:0] model_i(input int p, input int amp);
        return scale(rnd(32767.0 * $cos(2.0 * PI * p / 50.0)), amp);
    endfunction

    function automatic logic [15:0] model_q(input int p, input int amp);
        return scale(rnd(32767.0 * $sin(2.0 * PI * p / 50.0)), amp);
    endfunction

    // abort_at > 0: abort high at edge T+abort_at; -1: abort together with start.
    task automatic run_pulse(input int f, input int len, input int amp, input int off,
                             input int abort_at, input bit poke_start);
        int    base, n, exp_done, done_cnt, done_rel, valid_cnt, p;
        bit    aborted;
        beat_t b, e;
        base     = (off >= 50) ? off - 50 : off;
        aborted  = (abort_at > 0) && (abort_at < len);
        n        = aborted ? abort_at - 1 : len;
        exp_done = (len == 0) ? 1 : (aborted ? abort_at + 2 : len + 2);
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 5; k++) begin
                p = (base + k * f + j * 5 * f) % 50;
                b.i[16*k +: 16] = model_i(p, amp);
                b.q[16*k +: 16] = model_q(p, amp);
            end
            sb.push_back(b);
        end
        @(negedge clk100);
        start        = 1'b1;
        abort        = (abort_at == -1);
        demod_freq   = 4'(f);
        pulse_length = 11'(len);
        amplitude    = 15'(amp);
        phase_offset = 6'(off);
        @(posedge clk100);
        #1;
        start        = 1'b0;
        abort        = 1'b0;
        demod_freq   = ~demod_freq;
        pulse_length = 11'd1;
        amplitude    = 15'h1234;
        phase_offset = 6'd7;
        done_cnt  = 0;
        done_rel  = -1;
        valid_cnt = 0;
        for (int rel = 1; rel <= exp_done + 3; rel++) begin
            abort = (rel == abort_at);
            start = poke_start && (rel == 4);
            @(posedge clk100);
            @(negedge clk100);
            chk("valid", 80'(out_valid), 80'(rel >= 2 && rel <= n + 1));
            chk("busy", 80'(busy), 80'(rel <= exp_done));
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (out_valid) begin
                valid_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 80'(out_valid), 80'(0));
                end else begin
                    e = sb.pop_front();
                    chk("out_i", out_i, e.i);
                    chk("out_q", out_q, e.q);
                end
            end else begin
                chk("idle_i", out_i, 80'(0));
                chk("idle_q", out_q, 80'(0));
            end
        end
        start = 1'b0;
        abort = 1'b0;
        chk("done_cnt", 80'(done_cnt), 80'(1));
        chk("done_time", 80'(done_rel), 80'(exp_done));
        chk("beats", 80'(valid_cnt), 80'(n));
        chk("sample_count", 80'(sample_count), 80'(n));
        sb.delete();
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        demod_freq   = '0;
        pulse_length = '0;
        amplitude    = '0;
        phase_offset = '0;
        #23;
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_valid", 80'(out_valid), 80'(0));
        chk("rst_done", 80'(done), 80'(0));
        chk("rst_count", 80'(sample_count), 80'(0));
        @(negedge clk100);
        reset_n = 1'b1;
        repeat (2) @(negedge clk100);

        run_pulse(5, 4, 32767, 0, 0, 1'b0);
        run_pulse(0, 3, 16384, 0, -1, 1'b0);
        run_pulse(0, 2, 32767, 63, 0, 1'b0);
        run_pulse(7, 100, 20000, 11, 3, 1'b1);
        run_pulse(3, 3, 30000, 20, 3, 1'b0);
        run_pulse(4, 0, 32767, 0, 0, 1'b0);
        run_pulse(15, 5, 32767, 49, 0, 1'b0);
        run_pulse(9, 6, 12345, 37, 0, 1'b0);

        // Asynchronous reset in the middle of a running pulse.
        @(negedge clk100);
        start        = 1'b1;
        demod_freq   = 4'd3;
        pulse_length = 11'd20;
        amplitude    = 15'd30000;
        phase_offset = 6'd0;
        @(negedge clk100);
        start = 1'b0;
        repeat (4) @(negedge clk100);
        chk("pre_rst_valid", 80'(out_valid), 80'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 80'(busy), 80'(0));
        chk("arst_valid", 80'(out_valid), 80'(0));
        chk("arst_done", 80'(done), 80'(0));
        chk("arst_i", out_i, 80'(0));
        chk("arst_q", out_q, 80'(0));
        chk("arst_count", 80'(sample_count), 80'(0));
        @(negedge clk100);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk100);
            chk("post_rst_busy", 80'(busy), 80'(0));
        end
        run_pulse(2, 2, 1000, 5, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
